// File: rtl/ifetch_pkg.sv
// Shared widths, NOP encoding and the default instruction ROM image for the IF stage.
package ifetch_pkg;

    localparam int PC_W      = 6;
    localparam int INSTR_W   = 32;
    localparam int ROM_WORDS = 16;

    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    // Index 0 is the leftmost entry, matching the word order of the program.
    localparam logic [0:ROM_WORDS-1][INSTR_W-1:0] IF_ROM_INIT = '{
        32'h2001_0005,
        32'h2002_0003,
        32'h0022_1820,
        32'hAC03_0000,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000
    };

endpackage

// File: rtl/instr_rom.sv
// Asynchronous-read 16-word instruction ROM, contents taken from IF_ROM_INIT.
module instr_rom
    import ifetch_pkg::*;
(
    input  logic [3:0]         index,
    output logic [INSTR_W-1:0] data
);

    // Combinational table lookup.
    always_comb begin
        data = IF_ROM_INIT[index];
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// MIPS IF stage: ROM fetch, PC+4 adder, flush squash and the IF/ID register.
// Optional macro IFETCH_MISALIGN_CHECK_EN squashes fetches whose pc is not word aligned.
module instr_fetch_stage
    import ifetch_pkg::*;
#(
    parameter int ROM_WORDS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc,
    input  logic               flush,
    output logic [PC_W-1:0]    pc_plus_4,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    if_id_pc_plus_4,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               misaligned
);

    localparam int IDX_W = $clog2(ROM_WORDS);

    logic [INSTR_W-1:0] rom_data_s;
    logic               squash_s;
    logic [PC_W-1:0]    if_id_pc_plus_4_r;
    logic [INSTR_W-1:0] if_id_instr_r;

    instr_rom u_rom (
        .index (pc[IDX_W+1:2]),
        .data  (rom_data_s)
    );

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    logic pc_low_unused_s;
    assign pc_low_unused_s = ^pc[1:0];
    assign misaligned      = 1'b0;
`endif

    assign squash_s  = flush | misaligned;
    assign pc_plus_4 = pc + 6'd4;

    // Squash the fetched word to a NOP on flush or misaligned fetch.
    always_comb begin
        if (squash_s) begin
            instr = NOP;
        end else begin
            instr = rom_data_s;
        end
    end

    // IF/ID pipeline register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_instr_r     <= NOP;
            if_id_pc_plus_4_r <= 6'd0;
        end else begin
            if_id_instr_r     <= instr;
            if_id_pc_plus_4_r <= pc_plus_4;
        end
    end

    assign if_id_instr     = if_id_instr_r;
    assign if_id_pc_plus_4 = if_id_pc_plus_4_r;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed self-checking bench for instr_fetch_stage (combinational fetch and IF/ID register).
module tb_instr_fetch_stage;

    logic        clk;
    logic        reset;
    logic [5:0]  pc;
    logic        flush;
    logic [5:0]  pc_plus_4;
    logic [31:0] instr;
    logic [5:0]  if_id_pc_plus_4;
    logic [31:0] if_id_instr;
    logic        misaligned;

    int pass_cnt  = 0;
    int total_cnt = 0;

    instr_fetch_stage #(.ROM_WORDS(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc              (pc),
        .flush           (flush),
        .pc_plus_4       (pc_plus_4),
        .instr           (instr),
        .if_id_pc_plus_4 (if_id_pc_plus_4),
        .if_id_instr     (if_id_instr),
        .misaligned      (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_misaligned_instr;
        logic [31:0] exp_misaligned_flag;
`ifdef IFETCH_MISALIGN_CHECK_EN
        exp_misaligned_instr = 32'h0000_0000;
        exp_misaligned_flag  = 32'd1;
`else
        exp_misaligned_instr = 32'h2002_0003;
        exp_misaligned_flag  = 32'd0;
`endif
        reset = 1'b1;
        pc    = 6'd0;
        flush = 1'b0;

        // Combinational path before any clock edge.
        #1;
        check("instr_pc0",      instr,     32'h2001_0005);
        check("pp4_pc0",        pc_plus_4, 32'd4);
        check("misaligned_pc0", misaligned, 32'd0);
        flush = 1'b1;
        #0.5;
        check("instr_pc0_flush", instr,     32'h0000_0000);
        check("pp4_pc0_flush",   pc_plus_4, 32'd4);
        flush = 1'b0;
        pc    = 6'd4;
        #0.5;
        check("instr_pc4", instr,     32'h2002_0003);
        check("pp4_pc4",   pc_plus_4, 32'd8);
        pc = 6'd60;
        #0.5;
        check("instr_pc60", instr,     32'h0000_0000);
        check("pp4_wrap",   pc_plus_4, 32'd0);
        pc = 6'd5;
        #0.5;
        check("misaligned_pc5", misaligned, exp_misaligned_flag);
        check("instr_pc5",      instr,      exp_misaligned_instr);
        check("pp4_pc5",        pc_plus_4,  32'd9);

        // Reset edge with pc = 8 and flush high.
        pc    = 6'd8;
        flush = 1'b1;
        tick();
        check("rst_instr", if_id_instr,     32'h0000_0000);
        check("rst_pp4",   if_id_pc_plus_4, 32'd0);

        reset = 1'b0;
        flush = 1'b0;
        tick();
        check("ifid_instr_pc8", if_id_instr,     32'h0022_1820);
        check("ifid_pp4_pc8",   if_id_pc_plus_4, 32'd12);

        pc    = 6'd12;
        flush = 1'b1;
        tick();
        check("ifid_instr_flush", if_id_instr,     32'h0000_0000);
        check("ifid_pp4_flush",   if_id_pc_plus_4, 32'd16);

        flush = 1'b0;
        tick();
        check("ifid_instr_pc12", if_id_instr,     32'hAC03_0000);
        check("ifid_pp4_pc12",   if_id_pc_plus_4, 32'd16);

        pc = 6'd0;
        tick();
        check("ifid_instr_pc0", if_id_instr,     32'h2001_0005);
        check("ifid_pp4_pc0",   if_id_pc_plus_4, 32'd4);

        // Mid-stream reset clears the register.
        reset = 1'b1;
        pc    = 6'd4;
        tick();
        check("midrst_instr", if_id_instr,     32'h0000_0000);
        check("midrst_pp4",   if_id_pc_plus_4, 32'd0);

        reset = 1'b0;
        pc    = 6'd5;
        tick();
        check("ifid_instr_pc5", if_id_instr,     exp_misaligned_instr);
        check("ifid_pp4_pc5",   if_id_pc_plus_4, 32'd9);

        pc = 6'd60;
        tick();
        check("ifid_instr_pc60", if_id_instr,     32'h0000_0000);
        check("ifid_pp4_pc60",   if_id_pc_plus_4, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
